// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM stage: FSM states, op types, NOP constants
// and the decode functions used by mem_access and its extension datapath.
package mem_access_pkg;

    localparam int MEM_BYTE_CNT_W = 2;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_XFER = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    typedef enum logic [3:0] {
        INST_NOP = 4'd0,
        INST_ALU = 4'd1,
        INST_LB  = 4'd2,
        INST_LH  = 4'd3,
        INST_LW  = 4'd4,
        INST_LBU = 4'd5,
        INST_LHU = 4'd6,
        INST_SB  = 4'd7,
        INST_SH  = 4'd8,
        INST_SW  = 4'd9,
        INST_BR  = 4'd10,
        INST_JMP = 4'd11
    } inst_type_e;

    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;

    function automatic logic is_load(input inst_type_e t);
        case (t)
            INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: is_load = 1'b1;
            default:                                       is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input inst_type_e t);
        case (t)
            INST_SB, INST_SH, INST_SW: is_store = 1'b1;
            default:                   is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input inst_type_e t);
        is_mem_op = is_load(t) | is_store(t);
    endfunction

    // Index of the final byte of the access (byte count minus one)
    function automatic logic [MEM_BYTE_CNT_W-1:0] last_byte_idx(input inst_type_e t);
        case (t)
            INST_LH, INST_LHU, INST_SH: last_byte_idx = 2'd1;
            INST_LW, INST_SW:           last_byte_idx = 2'd3;
            default:                    last_byte_idx = 2'd0;
        endcase
    endfunction

    function automatic logic is_misaligned(input inst_type_e t, input logic [1:0] addr_lo);
        case (last_byte_idx(t))
            2'd1:    is_misaligned = addr_lo[0];
            2'd3:    is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ext.sv
// Byte datapath for the MEM stage: store byte selection by byte index and
// sign/zero extension of the assembled little-endian load buffer.
module mem_access_ext
    import mem_access_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  inst_type_e        inst_type_in,
    input  logic [IDX_W-1:0]  idx_in,
    input  logic [31:0]       st_data_in,
    input  logic [31:0]       buf_in,
    output logic [7:0]        wdata_out,
    output logic [31:0]       ld_val_out
);

    assign wdata_out = st_data_in[{idx_in, 3'b000} +: 8];

    // Load result extension selected by op type
    always_comb begin
        ld_val_out = buf_in;
        case (inst_type_in)
            INST_LB:  ld_val_out = {{24{buf_in[7]}}, buf_in[7:0]};
            INST_LH:  ld_val_out = {{16{buf_in[15]}}, buf_in[15:0]};
            INST_LBU: ld_val_out = {24'h00_0000, buf_in[7:0]};
            INST_LHU: ld_val_out = {16'h0000, buf_in[15:0]};
            INST_LW:  ld_val_out = buf_in;
            default:  ld_val_out = buf_in;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes non-memory ops to mem_wb, runs loads/stores byte-serially on the
// 8-bit memory port while stalling upstream. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int MAX_BYTES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rd_mem_in,
    input  logic [31:0] rd_val_mem_in,
    input  logic [4:0]  rd_addr_mem_in,
    input  inst_type_e  inst_type_mem_in,
    input  logic [31:0] st_data_mem_in,
    output logic        rd_wb_out,
    output logic [31:0] rd_val_wb_out,
    output logic [4:0]  rd_addr_wb_out,
    output logic        stallreq_mem_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [7:0]  mem_wdata_out,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_mem_out,
`endif
    input  logic        mem_ack_in,
    input  logic [7:0]  mem_rdata_in
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    mem_state_e        state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [31:0]       base_r;
    logic [31:0]       st_data_r;
    logic [31:0]       buf_r;
    logic              rd_r;
    logic [4:0]        rd_addr_r;
    inst_type_e        type_r;
`ifdef MEM_ALIGN_CHECK_EN
    logic              misalign_r;
`endif

    logic [IDX_W-1:0]  last_idx_s;
    logic [31:0]       ld_val_s;
    logic [7:0]        wdata_s;
    logic              load_wb_s;
    logic              rd_wb_s;
    logic [31:0]       rd_val_s;
    logic [4:0]        rd_addr_s;
    logic              stall_s;

    assign last_idx_s = IDX_W'(last_byte_idx(type_r));

`ifdef MEM_ALIGN_CHECK_EN
    assign load_wb_s        = is_load(type_r) & ~misalign_r;
    assign misalign_mem_out = ~rst_in & (state_r == MEM_DONE) & misalign_r;
`else
    assign load_wb_s        = is_load(type_r);
`endif

    mem_access_ext #(
        .IDX_W (IDX_W)
    ) u_ext (
        .inst_type_in (type_r),
        .idx_in       (idx_r),
        .st_data_in   (st_data_r),
        .buf_in       (buf_r),
        .wdata_out    (wdata_s),
        .ld_val_out   (ld_val_s)
    );

    // Transaction FSM: capture op in IDLE, walk bytes in XFER, present result in DONE
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r   <= MEM_IDLE;
            idx_r     <= {IDX_W{1'b0}};
            base_r    <= ZERO_WORD;
            st_data_r <= ZERO_WORD;
            buf_r     <= ZERO_WORD;
            rd_r      <= WRITE_DISABLE;
            rd_addr_r <= NOP_REG_ADDR;
            type_r    <= INST_NOP;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_r <= 1'b0;
`endif
        end else if (rdy_in) begin
            case (state_r)
                MEM_IDLE: begin
                    if (is_mem_op(inst_type_mem_in)) begin
                        base_r    <= rd_val_mem_in;
                        st_data_r <= st_data_mem_in;
                        rd_r      <= rd_mem_in;
                        rd_addr_r <= rd_addr_mem_in;
                        type_r    <= inst_type_mem_in;
                        idx_r     <= {IDX_W{1'b0}};
                        buf_r     <= ZERO_WORD;
`ifdef MEM_ALIGN_CHECK_EN
                        // Misaligned accesses skip the bus entirely and report in DONE
                        misalign_r <= is_misaligned(inst_type_mem_in, rd_val_mem_in[1:0]);
                        state_r    <= is_misaligned(inst_type_mem_in, rd_val_mem_in[1:0]) ?
                                      MEM_DONE : MEM_XFER;
`else
                        state_r   <= MEM_XFER;
`endif
                    end
                end
                MEM_XFER: begin
                    if (mem_ack_in) begin
                        if (is_load(type_r)) begin
                            buf_r[{idx_r, 3'b000} +: 8] <= mem_rdata_in;
                        end
                        if (idx_r == last_idx_s) begin
                            state_r <= MEM_DONE;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1'b1);
                        end
                    end
                end
                MEM_DONE: begin
                    state_r <= MEM_IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_r <= 1'b0;
`endif
                end
                default: state_r <= MEM_IDLE;
            endcase
        end
    end

    // Writeback and stall decode; non-memory ops bypass in IDLE with no added latency
    always_comb begin
        rd_wb_s   = WRITE_DISABLE;
        rd_val_s  = ZERO_WORD;
        rd_addr_s = NOP_REG_ADDR;
        stall_s   = 1'b0;
        if (rst_in) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                MEM_IDLE: begin
                    if (is_mem_op(inst_type_mem_in)) begin
                        stall_s = 1'b1;
                    end else begin
                        rd_wb_s   = rd_mem_in;
                        rd_val_s  = rd_val_mem_in;
                        rd_addr_s = rd_addr_mem_in;
                    end
                end
                MEM_XFER: stall_s = 1'b1;
                MEM_DONE: begin
                    rd_addr_s = rd_addr_r;
                    if (load_wb_s) begin
                        rd_wb_s  = rd_r;
                        rd_val_s = ld_val_s;
                    end else begin
                        rd_wb_s  = WRITE_DISABLE;
                    end
                end
                default: stall_s = 1'b0;
            endcase
        end
    end

    assign rd_wb_out        = rd_wb_s;
    assign rd_val_wb_out    = rd_val_s;
    assign rd_addr_wb_out   = rd_addr_s;
    assign stallreq_mem_out = stall_s;
    assign mem_req_out      = ~rst_in & (state_r == MEM_XFER);
    assign mem_we_out       = is_store(type_r);
    assign mem_addr_out     = base_r + 32'(idx_r);
    assign mem_wdata_out    = wdata_s;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: ex_mem/memory-controller driver, byte-level memory
// model and reference results computed from the load/store rules.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rd_mem_in;
    logic [31:0] rd_val_mem_in;
    logic [4:0]  rd_addr_mem_in;
    inst_type_e  inst_type_mem_in;
    logic [31:0] st_data_mem_in;
    logic        rd_wb_out;
    logic [31:0] rd_val_wb_out;
    logic [4:0]  rd_addr_wb_out;
    logic        stallreq_mem_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [7:0]  mem_wdata_out;
    logic        mem_ack_in;
    logic [7:0]  mem_rdata_in;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_mem_out;
`endif

    always #5 clk_in = ~clk_in;

    mem_access #(.MAX_BYTES(4)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .rd_mem_in        (rd_mem_in),
        .rd_val_mem_in    (rd_val_mem_in),
        .rd_addr_mem_in   (rd_addr_mem_in),
        .inst_type_mem_in (inst_type_mem_in),
        .st_data_mem_in   (st_data_mem_in),
        .rd_wb_out        (rd_wb_out),
        .rd_val_wb_out    (rd_val_wb_out),
        .rd_addr_wb_out   (rd_addr_wb_out),
        .stallreq_mem_out (stallreq_mem_out),
        .mem_req_out      (mem_req_out),
        .mem_we_out       (mem_we_out),
        .mem_addr_out     (mem_addr_out),
        .mem_wdata_out    (mem_wdata_out),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_mem_out (misalign_mem_out),
`endif
        .mem_ack_in       (mem_ack_in),
        .mem_rdata_in     (mem_rdata_in)
    );

    typedef struct {
        inst_type_e  t;
        logic        rd;
        logic [31:0] val;
        logic [4:0]  ra;
        logic [31:0] st;
    } op_t;
    typedef struct packed { logic [4:0] a; logic [31:0] v; } wb_t;
    typedef struct packed { logic we; logic [31:0] a; logic [7:0] d; } mreq_t;

    op_t   op_q[$];
    wb_t   wb_q[$];
    mreq_t mem_q[$];
    logic [7:0] mem_m [logic [31:0]];

    op_t cur;
    bit  cur_busy = 1'b0;
    int  cur_age, cur_stall;
    int  checks = 0, failures = 0;
    int  mis_pend = 0;
    int  ack_min = 0, ack_max = 0, rdy_low_pct = 0, rdy_force_low = 0;
    int  wait_cnt = 0, bytes_acc = 0;
    bit  exact = 1'b0, abort_run = 1'b0;
    bit  mon_stall = 1'b0, mon_req = 1'b0, prev_req = 1'b0;
    logic [40:0] prev_bundle;
    logic [31:0] held_addr;
    wb_t   mon_w;
    mreq_t mon_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic int nbytes(input inst_type_e t);
        case (t)
            INST_LB, INST_LBU, INST_SB: return 1;
            INST_LH, INST_LHU, INST_SH: return 2;
            INST_LW, INST_SW:           return 4;
            default:                    return 0;
        endcase
    endfunction

    function automatic bit misal(input op_t o);
`ifdef MEM_ALIGN_CHECK_EN
        int n = nbytes(o.t);
        return (n == 2 && o.val[0]) || (n == 4 && o.val[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(input op_t o);
        if (nbytes(o.t) == 0) return 1;
        if (misal(o)) return 2;
        return nbytes(o.t) + 2;
    endfunction

    // Reference behaviour: expected bus bytes, writeback and memory contents
    task automatic push_expect(input op_t o);
        int n = nbytes(o.t);
        bit st = (o.t == INST_SB || o.t == INST_SH || o.t == INST_SW);
        longint v = 0;
        logic [31:0] a;
        logic [7:0]  b;
        if (n == 0) begin
            if (o.rd) wb_q.push_back('{a: o.ra, v: o.val});
        end else if (misal(o)) begin
            mis_pend++;
        end else begin
            for (int k = 0; k < n; k++) begin
                a = o.val + k;
                if (st) begin
                    b = 8'((o.st >> (8 * k)) & 32'hFF);
                    mem_q.push_back('{we: 1'b1, a: a, d: b});
                    mem_m[a] = b;
                end else begin
                    b = byte_of(a);
                    mem_q.push_back('{we: 1'b0, a: a, d: 8'h00});
                    v = v + (longint'(b) << (8 * k));
                end
            end
            if ((o.t == INST_LB || o.t == INST_LH) && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n));
            if (!st && o.rd) wb_q.push_back('{a: o.ra, v: v[31:0]});
        end
    endtask

    task automatic add(input inst_type_e t, input logic rd, input logic [31:0] val,
                       input logic [4:0] ra, input logic [31:0] st);
        op_q.push_back('{t: t, rd: rd, val: val, ra: ra, st: st});
    endtask

    // One clock of ex_mem and memory-controller behaviour
    task automatic step();
        @(posedge clk_in);
        if (mon_req && mem_ack_in && rdy_in) begin
            bytes_acc++;
            wait_cnt = $urandom_range(ack_max, ack_min);
        end
        if (cur_busy) begin
            cur_age++;
            if (mon_stall) cur_stall++;
            if (rdy_in && !mon_stall) begin
                if (exact) begin
                    chk("latency", 64'(cur_age), 64'(exp_lat(cur)));
                    if (nbytes(cur.t) != 0) chk("stall_cycles", 64'(cur_stall), 64'(exp_lat(cur) - 1));
                end
                cur_busy = 1'b0;
            end else if (cur_age > 400) begin
                fail_now("timeout_op_not_consumed");
                abort_run = 1'b1;
            end
        end
        #1;
        if (!cur_busy && op_q.size() > 0) begin
            cur = op_q.pop_front();
            cur_busy = 1'b1;
            cur_age = 0;
            cur_stall = 0;
            wait_cnt = $urandom_range(ack_max, ack_min);
            push_expect(cur);
        end else if (!cur_busy) begin
            cur = '{t: INST_NOP, rd: 1'b0, val: $urandom, ra: 5'd0, st: $urandom};
        end
        inst_type_mem_in = cur.t;
        rd_mem_in        = cur.rd;
        rd_val_mem_in    = cur.val;
        rd_addr_mem_in   = cur.ra;
        st_data_mem_in   = cur.st;
        if (rdy_force_low > 0) begin
            rdy_in = 1'b0;
            rdy_force_low--;
        end else begin
            rdy_in = ($urandom_range(99, 0) >= rdy_low_pct);
        end
        mem_ack_in = 1'b0;
        if (mem_req_out) begin
            if (wait_cnt == 0) begin
                mem_ack_in   = 1'b1;
                mem_rdata_in = byte_of(mem_addr_out);
            end else begin
                wait_cnt--;
            end
        end
    endtask

    task automatic run_all();
        while ((op_q.size() > 0 || cur_busy) && !abort_run) step();
        repeat (3) step();
    endtask

    // Monitor: compare DUT writebacks and bus bytes against the scoreboard queues
    always @(negedge clk_in) begin
        if (rst_in) begin
            mon_stall = 1'b0;
            mon_req   = 1'b0;
            prev_req  = 1'b0;
        end else begin
            mon_stall = stallreq_mem_out;
            mon_req   = mem_req_out;
            if (rd_wb_out && rdy_in) begin
                if (wb_q.size() == 0) begin
                    fail_now("wb_unexpected");
                end else begin
                    mon_w = wb_q.pop_front();
                    chk("wb_addr", 64'(rd_addr_wb_out), 64'(mon_w.a));
                    chk("wb_val", 64'(rd_val_wb_out), 64'(mon_w.v));
                end
            end
            if (mem_req_out && prev_req)
                chk("req_stable", 64'({mem_we_out, mem_addr_out, mem_wdata_out}), 64'(prev_bundle));
            if (mem_req_out && mem_ack_in && rdy_in) begin
                if (mem_q.size() == 0) begin
                    fail_now("mem_req_unexpected");
                end else begin
                    mon_m = mem_q.pop_front();
                    chk("mem_we", 64'(mem_we_out), 64'(mon_m.we));
                    chk("mem_addr", 64'(mem_addr_out), 64'(mon_m.a));
                    if (mon_m.we) chk("mem_wdata", 64'(mem_wdata_out), 64'(mon_m.d));
                end
            end
`ifdef MEM_ALIGN_CHECK_EN
            if (misalign_mem_out && rdy_in) begin
                if (mis_pend == 0) fail_now("misalign_unexpected");
                else begin
                    checks++;
                    mis_pend--;
                end
            end
`endif
            prev_req    = mem_req_out && !(mem_ack_in && rdy_in);
            prev_bundle = {mem_we_out, mem_addr_out, mem_wdata_out};
        end
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        mem_ack_in = 1'b0;
        mem_rdata_in = 8'h00;
        inst_type_mem_in = INST_ALU;
        rd_mem_in = 1'b1;
        rd_val_mem_in = 32'hDEAD_BEEF;
        rd_addr_mem_in = 5'd9;
        st_data_mem_in = 32'h0;
        #12;
        chk("rst_rd_wb", 64'(rd_wb_out), 64'(0));
        chk("rst_rd_val", 64'(rd_val_wb_out), 64'(0));
        chk("rst_rd_addr", 64'(rd_addr_wb_out), 64'(0));
        chk("rst_stall", 64'(stallreq_mem_out), 64'(0));
        chk("rst_mem_req", 64'(mem_req_out), 64'(0));
        @(posedge clk_in);
        #1;
        inst_type_mem_in = INST_NOP;
        rd_mem_in = 1'b0;
        rst_in = 1'b0;

        // Directed, ack every cycle, no freezes: exact latency and stall length
        exact = 1'b1;
        mem_m[32'h100] = 8'h78; mem_m[32'h101] = 8'h56;
        mem_m[32'h102] = 8'h34; mem_m[32'h103] = 8'h12;
        mem_m[32'h7]   = 8'h80;
        mem_m[32'h40]  = 8'h00; mem_m[32'h41] = 8'h80;
        add(INST_ALU, 1'b1, 32'h0000_1234, 5'd5, 32'h0);
        add(INST_LW,  1'b1, 32'h0000_0100, 5'd7, 32'h0);
        add(INST_LB,  1'b1, 32'h0000_0007, 5'd8, 32'h0);
        add(INST_LBU, 1'b1, 32'h0000_0007, 5'd9, 32'h0);
        add(INST_LH,  1'b1, 32'h0000_0040, 5'd10, 32'h0);
        add(INST_SB,  1'b1, 32'h0000_0050, 5'd11, 32'h1122_33EE);
        add(INST_LW,  1'b1, 32'h0000_0102, 5'd12, 32'h0);
        add(INST_BR,  1'b0, 32'h0000_5555, 5'd13, 32'h0);
        run_all();
        exact = 1'b0;

        // SH with each byte acked after three waiting cycles
        ack_min = 3; ack_max = 3;
        add(INST_SH, 1'b1, 32'h0000_0020, 5'd14, 32'hAABB_CCDD);
        run_all();
        ack_min = 0; ack_max = 0;

        // Two frozen cycles mid-XFER with ack held high: index must not move
        add(INST_LW, 1'b1, 32'h0000_0100, 5'd15, 32'h0);
        bytes_acc = 0;
        for (int i = 0; i < 50 && bytes_acc < 1; i++) step();
        rdy_in = 1'b0;
        held_addr = mem_addr_out;
        chk("rdy_addr_before", 64'(held_addr), 64'(32'h101));
        rdy_force_low = 1;
        step();
        step();
        chk("rdy_addr_held", 64'(mem_addr_out), 64'(32'h101));
        run_all();

        // Reset in the middle of an LW after two accepted bytes
        add(INST_LW, 1'b1, 32'h0000_0100, 5'd16, 32'h0);
        bytes_acc = 0;
        for (int i = 0; i < 50 && bytes_acc < 2; i++) step();
        chk("pre_reset_req", 64'(mem_req_out), 64'(1));
        #2;
        rst_in = 1'b1;
        #1;
        chk("reset_req_drop", 64'(mem_req_out), 64'(0));
        chk("reset_stall_drop", 64'(stallreq_mem_out), 64'(0));
        chk("reset_no_wb", 64'(rd_wb_out), 64'(0));
        inst_type_mem_in = INST_NOP;
        rd_mem_in = 1'b0;
        mem_ack_in = 1'b0;
        rdy_in = 1'b1;
        cur_busy = 1'b0;
        cur = '{t: INST_NOP, rd: 1'b0, val: 32'h0, ra: 5'd0, st: 32'h0};
        wb_q.delete();
        mem_q.delete();
        @(posedge clk_in);
        #3;
        rst_in = 1'b0;
        step();
        step();
        chk("post_reset_req", 64'(mem_req_out), 64'(0));
        chk("post_reset_stall", 64'(stallreq_mem_out), 64'(0));

        // Randomized traffic with variable ack delay and freezes, incl. address wrap
        ack_min = 0; ack_max = 2; rdy_low_pct = 20;
        for (int i = 0; i < 160; i++) begin
            inst_type_e t = inst_type_e'(4'($urandom_range(11, 0)));
            logic [31:0] a;
            if ($urandom_range(15, 0) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
            else a = 32'($urandom_range(63, 0));
            if (nbytes(t) == 0) a = $urandom;
            add(t, 1'($urandom_range(3, 0) != 0), a, 5'($urandom_range(31, 0)), $urandom);
        end
        run_all();

        chk("wb_q_drained", 64'(wb_q.size()), 64'(0));
        chk("mem_q_drained", 64'(mem_q.size()), 64'(0));
        chk("misalign_drained", 64'(mis_pend), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
